// File: rtl/ltc2656_spi_driver_if.sv
// Command/status bus between the DAC register block (master) and the LTC2656 SPI driver (slave).
interface ltc2656_spi_driver_if;
  logic [1:0]  command;
  logic [3:0]  dac_cmd;
  logic [3:0]  dac_channel;
  logic [15:0] dac_value;
  logic        busy;
  logic        overrun;
  logic [23:0] rx_word;
  logic        rx_valid;

  modport master (
    output command, dac_cmd, dac_channel, dac_value,
    input  busy, overrun, rx_word, rx_valid
  );

  modport slave (
    input  command, dac_cmd, dac_channel, dac_value,
    output busy, overrun, rx_word, rx_valid
  );
endinterface

// File: rtl/ltc2656_spi_driver.sv
// LTC2656 octal DAC pin driver: 24-bit MSB-first SPI write plus timed LDAC/CLR pulses.
// Optional SDO capture is built when LTC2656_READBACK_EN is defined.
module ltc2656_spi_driver #(
  parameter int CLK_DIV = 4,
  parameter int PULSE_W = 8
) (
  input  logic                       clk_i,
  input  logic                       resetn_i,
  ltc2656_spi_driver_if.slave        ctrl,
  output logic                       dac_sck_o,
  output logic                       dac_sdi_o,
  output logic                       dac_cs_n_o,
  output logic                       dac_ldac_n_o,
  output logic                       dac_clr_n_o,
  input  logic                       dac_sdo_i
);

  typedef enum logic [2:0] {IDLE, SETUP, SCK_HI, SCK_LO, CS_HIGH, PULSE} state_e;

  localparam logic [1:0] CMD_NONE = 2'd0;
  localparam logic [1:0] CMD_XFER = 2'd1;
  localparam logic [1:0] CMD_LDAC = 2'd2;
  localparam logic [1:0] CMD_CLR  = 2'd3;

  localparam logic [7:0] DIV_LAST   = 8'(CLK_DIV - 1);
  localparam logic [7:0] PULSE_LAST = 8'(PULSE_W - 1);

  state_e      state_q, state_d;
  logic [7:0]  phase_q, phase_d;
  logic [4:0]  bit_q, bit_d;
  logic [23:0] word_q, word_d;
  logic        busy_q, busy_d;
  logic        overrun_q, overrun_d;
  logic        sck_q, sck_d;
  logic        sdi_q, sdi_d;
  logic        cs_n_q, cs_n_d;
  logic        ldac_n_q, ldac_n_d;
  logic        clr_n_q, clr_n_d;
  logic        div_done;

  assign div_done = (phase_q == DIV_LAST);

  always_comb begin
    state_d   = state_q;
    phase_d   = phase_q;
    bit_d     = bit_q;
    word_d    = word_q;
    busy_d    = busy_q;
    overrun_d = 1'b0;
    sck_d     = sck_q;
    sdi_d     = sdi_q;
    cs_n_d    = cs_n_q;
    ldac_n_d  = ldac_n_q;
    clr_n_d   = clr_n_q;

    // Commands are only honoured in IDLE; anything else is reported and dropped.
    if (state_q != IDLE && ctrl.command != CMD_NONE) begin
      overrun_d = 1'b1;
    end

    unique case (state_q)
      IDLE: begin
        phase_d = 8'd0;
        unique case (ctrl.command)
          CMD_XFER: begin
            word_d  = {ctrl.dac_cmd, ctrl.dac_channel, ctrl.dac_value};
            sdi_d   = ctrl.dac_cmd[3];
            cs_n_d  = 1'b0;
            busy_d  = 1'b1;
            bit_d   = 5'd23;
            state_d = SETUP;
          end
          CMD_LDAC: begin
            ldac_n_d = 1'b0;
            busy_d   = 1'b1;
            state_d  = PULSE;
          end
          CMD_CLR: begin
            clr_n_d = 1'b0;
            busy_d  = 1'b1;
            state_d = PULSE;
          end
          default: ;
        endcase
      end
      SETUP: begin
        phase_d = phase_q + 8'd1;
        if (div_done) begin
          phase_d = 8'd0;
          sck_d   = 1'b1;
          state_d = SCK_HI;
        end
      end
      SCK_HI: begin
        phase_d = phase_q + 8'd1;
        if (div_done) begin
          phase_d = 8'd0;
          sck_d   = 1'b0;
          state_d = SCK_LO;
          // The last bit stays on SDI after its rising edge.
          if (bit_q != 5'd0) begin
            sdi_d  = word_q[22];
            word_d = {word_q[22:0], 1'b0};
          end
        end
      end
      SCK_LO: begin
        phase_d = phase_q + 8'd1;
        if (div_done) begin
          phase_d = 8'd0;
          if (bit_q != 5'd0) begin
            bit_d   = bit_q - 5'd1;
            sck_d   = 1'b1;
            state_d = SCK_HI;
          end else begin
            cs_n_d  = 1'b1;
            state_d = CS_HIGH;
          end
        end
      end
      CS_HIGH: begin
        phase_d = phase_q + 8'd1;
        if (div_done) begin
          phase_d = 8'd0;
          busy_d  = 1'b0;
          state_d = IDLE;
        end
      end
      PULSE: begin
        phase_d = phase_q + 8'd1;
        if (phase_q == PULSE_LAST) begin
          phase_d  = 8'd0;
          ldac_n_d = 1'b1;
          clr_n_d  = 1'b1;
          busy_d   = 1'b0;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!resetn_i) begin
      state_q   <= IDLE;
      phase_q   <= 8'd0;
      bit_q     <= 5'd0;
      word_q    <= 24'd0;
      busy_q    <= 1'b0;
      overrun_q <= 1'b0;
      sck_q     <= 1'b0;
      sdi_q     <= 1'b0;
      cs_n_q    <= 1'b1;
      ldac_n_q  <= 1'b1;
      clr_n_q   <= 1'b1;
    end else begin
      state_q   <= state_d;
      phase_q   <= phase_d;
      bit_q     <= bit_d;
      word_q    <= word_d;
      busy_q    <= busy_d;
      overrun_q <= overrun_d;
      sck_q     <= sck_d;
      sdi_q     <= sdi_d;
      cs_n_q    <= cs_n_d;
      ldac_n_q  <= ldac_n_d;
      clr_n_q   <= clr_n_d;
    end
  end

  assign ctrl.busy    = busy_q;
  assign ctrl.overrun = overrun_q;
  assign dac_sck_o    = sck_q;
  assign dac_sdi_o    = sdi_q;
  assign dac_cs_n_o   = cs_n_q;
  assign dac_ldac_n_o = ldac_n_q;
  assign dac_clr_n_o  = clr_n_q;

`ifdef LTC2656_READBACK_EN
  logic [23:0] rx_sh_q, rx_sh_d;
  logic [23:0] rx_word_q, rx_word_d;
  logic        rx_valid_q, rx_valid_d;

  // SDO is sampled in the same cycle SCK is driven high, then published as CS rises.
  always_comb begin
    rx_sh_d    = rx_sh_q;
    rx_word_d  = rx_word_q;
    rx_valid_d = 1'b0;
    if (sck_d && !sck_q) begin
      rx_sh_d = {rx_sh_q[22:0], dac_sdo_i};
    end
    if (state_q == SCK_LO && state_d == CS_HIGH) begin
      rx_word_d  = rx_sh_q;
      rx_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!resetn_i) begin
      rx_sh_q    <= 24'd0;
      rx_word_q  <= 24'd0;
      rx_valid_q <= 1'b0;
    end else begin
      rx_sh_q    <= rx_sh_d;
      rx_word_q  <= rx_word_d;
      rx_valid_q <= rx_valid_d;
    end
  end

  assign ctrl.rx_word  = rx_word_q;
  assign ctrl.rx_valid = rx_valid_q;
`else
  logic sdo_unused;
  assign sdo_unused    = dac_sdo_i;
  assign ctrl.rx_word  = 24'd0;
  assign ctrl.rx_valid = 1'b0;
`endif

endmodule

// File: tb/tb_ltc2656_spi_driver.sv
// Directed bench for ltc2656_spi_driver with a shift-register DAC model on the SPI pins.
// Define LTC2656_READBACK_EN to also exercise the SDO capture path.
module tb_ltc2656_spi_driver;

  localparam int CLK_DIV = 4;
  localparam int PULSE_W = 8;

  localparam logic [1:0] CMD_XFER = 2'd1;
  localparam logic [1:0] CMD_LDAC = 2'd2;
  localparam logic [1:0] CMD_CLR  = 2'd3;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  logic dacSck, dacSdi, dacCsN, dacLdacN, dacClrN, dacSdo;

  ltc2656_spi_driver_if ctrl ();

  ltc2656_spi_driver #(.CLK_DIV(CLK_DIV), .PULSE_W(PULSE_W)) dut (
    .clk_i        (clk),
    .resetn_i     (resetn),
    .ctrl         (ctrl),
    .dac_sck_o    (dacSck),
    .dac_sdi_o    (dacSdi),
    .dac_cs_n_o   (dacCsN),
    .dac_ldac_n_o (dacLdacN),
    .dac_clr_n_o  (dacClrN),
    .dac_sdo_i    (dacSdo)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // DAC model: counts SCK rising edges and shifts SDI in MSB-first.
  int          sckEdges = 0;
  int          csFallEdges = 0;
  logic [23:0] dacWord = 24'd0;
  logic [23:0] sdoPattern = 24'h5A5A5A;
  int          sdoIdx;

  always @(posedge dacSck) begin
    sckEdges <= sckEdges + 1;
    dacWord  <= {dacWord[22:0], dacSdi};
  end

  always @(negedge dacCsN) csFallEdges <= sckEdges;

  assign sdoIdx = sckEdges - csFallEdges;
  assign dacSdo = (sdoIdx >= 0 && sdoIdx < 24) ? sdoPattern[23 - sdoIdx] : 1'b0;

  // Cumulative per-cycle activity, sampled on the falling clock edge.
  int          busyCycles = 0, csLowCycles = 0, csHighCycles = 0, overrunPulses = 0;
  int          ldacLowCycles = 0, clrLowCycles = 0, spiActiveCycles = 0;
  int          rxValidPulses = 0, rxValidCsHigh = 0;
  logic [23:0] rxWordLast = 24'd0;

  always @(negedge clk) begin
    if (ctrl.busy)          busyCycles      <= busyCycles + 1;
    if (!dacCsN)            csLowCycles     <= csLowCycles + 1;
    if (dacCsN)             csHighCycles    <= csHighCycles + 1;
    if (ctrl.overrun)       overrunPulses   <= overrunPulses + 1;
    if (!dacLdacN)          ldacLowCycles   <= ldacLowCycles + 1;
    if (!dacClrN)           clrLowCycles    <= clrLowCycles + 1;
    if (!dacCsN || dacSck)  spiActiveCycles <= spiActiveCycles + 1;
    if (ctrl.rx_valid) begin
      rxValidPulses <= rxValidPulses + 1;
      rxWordLast    <= ctrl.rx_word;
      if (dacCsN) rxValidCsHigh <= rxValidCsHigh + 1;
    end
  end

  task automatic stepCycle();
    @(negedge clk);
    #1;
  endtask

  task automatic issueCmd(input logic [1:0] cmd, input logic [23:0] w);
    ctrl.command     = cmd;
    ctrl.dac_cmd     = w[23:20];
    ctrl.dac_channel = w[19:16];
    ctrl.dac_value   = w[15:0];
    stepCycle();
    ctrl.command = 2'd0;
  endtask

  task automatic waitIdle();
    int n = 0;
    while (ctrl.busy && n < 2000) begin
      stepCycle();
      n++;
    end
  endtask

  function automatic logic [7:0] pinVector();
    return {ctrl.busy, ctrl.overrun, dacSck, dacSdi, dacCsN, dacLdacN, dacClrN, ctrl.rx_valid};
  endfunction

  task automatic test_reset();
    resetn = 1'b0;
    repeat (3) stepCycle();
    vectors++;
    if (pinVector() !== 8'b0000_1110) begin
      miscompares++;
      $display("[TB] FAIL reset_pins: got %b expected %b", pinVector(), 8'b0000_1110);
    end
    vectors++;
    if (ctrl.rx_word !== 24'd0) begin
      miscompares++;
      $display("[TB] FAIL reset_rx_word: got %h expected %h", ctrl.rx_word, 24'd0);
    end
    resetn = 1'b1;
    stepCycle();
    vectors++;
    if (pinVector() !== 8'b0000_1110) begin
      miscompares++;
      $display("[TB] FAIL idle_after_reset: got %b expected %b", pinVector(), 8'b0000_1110);
    end
  endtask

  task automatic test_xfer();
    int b0 = busyCycles, c0 = csLowCycles, e0 = sckEdges, p0 = ldacLowCycles + clrLowCycles;
    int r0 = rxValidPulses, rc0 = rxValidCsHigh;
    issueCmd(CMD_XFER, 24'h32A5C3);
    vectors++;
    if ({ctrl.busy, dacCsN, dacSdi} !== 3'b100) begin
      miscompares++;
      $display("[TB] FAIL xfer_start busy/cs_n/sdi: got %b expected %b", {ctrl.busy, dacCsN, dacSdi}, 3'b100);
    end
    waitIdle();
    vectors++;
    if (sckEdges - e0 != 24) begin
      miscompares++;
      $display("[TB] FAIL xfer_sck_edges: got %0d expected %0d", sckEdges - e0, 24);
    end
    vectors++;
    if (dacWord !== 24'h32A5C3) begin
      miscompares++;
      $display("[TB] FAIL xfer_word: got %h expected %h", dacWord, 24'h32A5C3);
    end
    vectors++;
    if (busyCycles - b0 != 200) begin
      miscompares++;
      $display("[TB] FAIL xfer_busy_cycles: got %0d expected %0d", busyCycles - b0, 200);
    end
    vectors++;
    if (csLowCycles - c0 != 196) begin
      miscompares++;
      $display("[TB] FAIL xfer_cs_low_cycles: got %0d expected %0d", csLowCycles - c0, 196);
    end
    vectors++;
    if (ldacLowCycles + clrLowCycles - p0 != 0) begin
      miscompares++;
      $display("[TB] FAIL xfer_pulse_pins: got %0d low cycles expected %0d", ldacLowCycles + clrLowCycles - p0, 0);
    end
`ifdef LTC2656_READBACK_EN
    vectors++;
    if (rxValidPulses - r0 != 1 || rxValidCsHigh - rc0 != 1) begin
      miscompares++;
      $display("[TB] FAIL readback_valid: got %0d pulses (%0d at cs high) expected 1", rxValidPulses - r0, rxValidCsHigh - rc0);
    end
    vectors++;
    if (rxWordLast !== 24'h5A5A5A) begin
      miscompares++;
      $display("[TB] FAIL readback_word: got %h expected %h", rxWordLast, 24'h5A5A5A);
    end
`else
    vectors++;
    if (rxValidPulses - r0 != 0 || rxValidCsHigh - rc0 != 0 || ctrl.rx_word !== 24'd0) begin
      miscompares++;
      $display("[TB] FAIL readback_disabled: got %0d pulses word %h expected 0 pulses word 000000", rxValidPulses - r0, ctrl.rx_word);
    end
`endif
  endtask

  task automatic test_pulse(input logic [1:0] cmd, input string name);
    int b0 = busyCycles, s0 = spiActiveCycles, l0 = ldacLowCycles, k0 = clrLowCycles;
    int selLow, otherLow;
    issueCmd(cmd, 24'h000000);
    waitIdle();
    selLow   = (cmd == CMD_LDAC) ? ldacLowCycles - l0 : clrLowCycles - k0;
    otherLow = (cmd == CMD_LDAC) ? clrLowCycles - k0 : ldacLowCycles - l0;
    vectors++;
    if (selLow != PULSE_W) begin
      miscompares++;
      $display("[TB] FAIL %s_low_cycles: got %0d expected %0d", name, selLow, PULSE_W);
    end
    vectors++;
    if (busyCycles - b0 != PULSE_W) begin
      miscompares++;
      $display("[TB] FAIL %s_busy_cycles: got %0d expected %0d", name, busyCycles - b0, PULSE_W);
    end
    vectors++;
    if (otherLow != 0 || spiActiveCycles - s0 != 0) begin
      miscompares++;
      $display("[TB] FAIL %s_other_pins: got other=%0d spi=%0d expected 0 0", name, otherLow, spiActiveCycles - s0);
    end
    vectors++;
    if ({dacLdacN, dacClrN} !== 2'b11) begin
      miscompares++;
      $display("[TB] FAIL %s_release: got %b expected %b", name, {dacLdacN, dacClrN}, 2'b11);
    end
  endtask

  task automatic test_overrun();
    int b0 = busyCycles, e0 = sckEdges, o0 = overrunPulses;
    issueCmd(CMD_XFER, 24'h3155AA);
    repeat (9) stepCycle();
    issueCmd(CMD_XFER, 24'h2F0F0F);
    vectors++;
    if (ctrl.overrun !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL overrun_next_cycle: got %b expected %b", ctrl.overrun, 1'b1);
    end
    waitIdle();
    vectors++;
    if (overrunPulses - o0 != 1) begin
      miscompares++;
      $display("[TB] FAIL overrun_pulses: got %0d expected %0d", overrunPulses - o0, 1);
    end
    vectors++;
    if (dacWord !== 24'h3155AA || sckEdges - e0 != 24) begin
      miscompares++;
      $display("[TB] FAIL overrun_word: got %h/%0d edges expected %h/24 edges", dacWord, sckEdges - e0, 24'h3155AA);
    end
    vectors++;
    if (busyCycles - b0 != 200) begin
      miscompares++;
      $display("[TB] FAIL overrun_busy_cycles: got %0d expected %0d", busyCycles - b0, 200);
    end
  endtask

  task automatic test_back_to_back();
    int e0 = sckEdges, o0 = overrunPulses, h0, b1;
    issueCmd(CMD_XFER, 24'h301234);
    h0 = csHighCycles;
    waitIdle();
    b1 = busyCycles;
    issueCmd(CMD_XFER, 24'h27BEEF);
    // CS stays high through the CLK_DIV cycles of CS_HIGH plus the single idle accept cycle.
    vectors++;
    if (csHighCycles - h0 != CLK_DIV + 1) begin
      miscompares++;
      $display("[TB] FAIL b2b_cs_gap: got %0d expected %0d", csHighCycles - h0, CLK_DIV + 1);
    end
    waitIdle();
    vectors++;
    if (dacWord !== 24'h27BEEF || sckEdges - e0 != 48) begin
      miscompares++;
      $display("[TB] FAIL b2b_second_word: got %h/%0d edges expected %h/48 edges", dacWord, sckEdges - e0, 24'h27BEEF);
    end
    vectors++;
    if (busyCycles - b1 != 200 || overrunPulses - o0 != 0) begin
      miscompares++;
      $display("[TB] FAIL b2b_busy_overrun: got busy=%0d overrun=%0d expected 200 0", busyCycles - b1, overrunPulses - o0);
    end
  endtask

  task automatic test_reset_mid_xfer();
    int e0 = sckEdges, n = 0, b0;
    issueCmd(CMD_XFER, 24'h3C0FF0);
    while (sckEdges - e0 < 10 && n < 1000) begin
      stepCycle();
      n++;
    end
    vectors++;
    if (sckEdges - e0 != 10) begin
      miscompares++;
      $display("[TB] FAIL midreset_edge_wait: got %0d expected %0d", sckEdges - e0, 10);
    end
    resetn = 1'b0;
    stepCycle();
    vectors++;
    if (pinVector() !== 8'b0000_1110 || ctrl.rx_word !== 24'd0) begin
      miscompares++;
      $display("[TB] FAIL midreset_pins: got %b/%h expected %b/000000", pinVector(), ctrl.rx_word, 8'b0000_1110);
    end
    resetn = 1'b1;
    stepCycle();
    e0 = sckEdges;
    b0 = busyCycles;
    issueCmd(CMD_XFER, 24'h0FFFF0);
    waitIdle();
    vectors++;
    if (dacWord !== 24'h0FFFF0 || sckEdges - e0 != 24) begin
      miscompares++;
      $display("[TB] FAIL midreset_next_word: got %h/%0d edges expected %h/24 edges", dacWord, sckEdges - e0, 24'h0FFFF0);
    end
    vectors++;
    if (busyCycles - b0 != 200) begin
      miscompares++;
      $display("[TB] FAIL midreset_busy_cycles: got %0d expected %0d", busyCycles - b0, 200);
    end
  endtask

  initial begin
    ctrl.command     = 2'd0;
    ctrl.dac_cmd     = 4'd0;
    ctrl.dac_channel = 4'd0;
    ctrl.dac_value   = 16'd0;
    test_reset();
    test_xfer();
    test_pulse(CMD_LDAC, "ldac");
    test_pulse(CMD_CLR, "clr");
    test_overrun();
    test_back_to_back();
    test_reset_mid_xfer();
    repeat (4) stepCycle();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
